// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the fetch PC, captures memory words into a small
// valid/ready output buffer, and handles execute redirects. Optional: FETCH_MISALIGN_CHK_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        imem_valid,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        fetch_misalign
`endif
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    logic [31:0]      pc;
    logic [31:0]      buf_pc    [BUF_DEPTH];
    logic [31:0]      buf_instr [BUF_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             mem_armed;
    logic             halted;
    logic             push;
    logic             pop;

    // The memory may not assert valid in the first cycle after reset; mask it anyway.
    assign pop  = (count != '0) && id_ready;
    assign push = imem_valid && mem_armed && !redirect && !halted
                  && ((count < DEPTH_C) || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            mem_armed <= 1'b0;
        end else begin
            mem_armed <= 1'b1;
            if (redirect) begin
                pc    <= {redirect_pc[31:2], 2'b00};
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    buf_pc[tail]    <= pc;
                    buf_instr[tail] <= imem_instr;
                    tail            <= tail + PTR_W'(1);
                    pc              <= pc + 32'd4;
                end
                if (pop) begin
                    head <= head + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (redirect) begin
            halted <= |redirect_pc[1:0];
        end
    end

    assign fetch_misalign = halted;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign halted          = 1'b0;
`endif

    // Outputs come from the head register; zeroed while empty so reset reads as 0.
    assign imem_pc  = pc;
    assign id_valid = (count != '0);
    assign id_instr = id_valid ? buf_instr[head] : '0;
    assign id_pc    = id_valid ? buf_pc[head]    : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a one-cycle-latency memory model.
// Memory returns word {16'hC0DE, pc[15:0]} for every address.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        imem_valid;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_misalign;
`endif

    int checks = 0;
    int errors = 0;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .BUF_DEPTH(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_pc    (imem_pc),
        .imem_instr (imem_instr),
        .imem_valid (imem_valid),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .fetch_misalign(fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    // Memory: registered data, valid only when the PC is unchanged from last cycle.
    logic [31:0] last_pc = '0;
    logic [31:0] mem_word = '0;
    logic        mem_ok = 1'b0;
    always @(posedge clk) begin
        last_pc  <= imem_pc;
        mem_word <= {16'hC0DE, imem_pc[15:0]};
        mem_ok   <= !rst;
    end
    assign imem_instr = mem_word;
    assign imem_valid = mem_ok && (imem_pc == last_pc);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [7] = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8, 32'h8, 32'hC};
        logic        exp_v  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exp_id [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8};
        id_ready = 1'b1;
        do_reset();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %b exp 0", id_valid); end
        checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_id_instr got %h exp 0", id_instr); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc got %h exp 0", id_pc); end
        checks++; if (imem_pc !== 32'h0) begin errors++; $display("FAIL reset_imem_pc got %h exp 0", imem_pc); end
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (imem_pc !== exp_pc[c]) begin errors++; $display("FAIL stream_imem_pc c%0d got %h exp %h", c, imem_pc, exp_pc[c]); end
            checks++;
            if (id_valid !== exp_v[c]) begin errors++; $display("FAIL stream_id_valid c%0d got %b exp %b", c, id_valid, exp_v[c]); end
            if (exp_v[c]) begin
                checks++;
                if (id_pc !== exp_id[c]) begin errors++; $display("FAIL stream_id_pc c%0d got %h exp %h", c, id_pc, exp_id[c]); end
                checks++;
                if (id_instr !== {16'hC0DE, exp_id[c][15:0]}) begin
                    errors++; $display("FAIL stream_id_instr c%0d got %h exp %h", c, id_instr, {16'hC0DE, exp_id[c][15:0]});
                end
            end
            step();
        end
    endtask

    task automatic test_stall_and_full_push_pop();
        logic [31:0] exp_id  [4] = '{32'h4, 32'h8, 32'hC, 32'h0};
        logic        exp_v   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp_pc  [4] = '{32'hC, 32'hC, 32'h10, 32'h10};
        id_ready = 1'b0;
        do_reset();
        repeat (4) step();
        for (int c = 0; c < 10; c++) begin
            checks++; if (imem_pc !== 32'h8) begin errors++; $display("FAIL stall_imem_pc c%0d got %h exp 8", c, imem_pc); end
            checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL stall_id_valid c%0d got %b exp 1", c, id_valid); end
            checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL stall_id_pc c%0d got %h exp 0", c, id_pc); end
            checks++; if (id_instr !== 32'hC0DE_0000) begin errors++; $display("FAIL stall_id_instr c%0d got %h exp c0de0000", c, id_instr); end
            step();
        end
        // Full, word valid, and decode now ready: push and pop in the same cycle.
        id_ready = 1'b1;
        step();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (id_valid !== exp_v[c]) begin errors++; $display("FAIL drain_id_valid c%0d got %b exp %b", c, id_valid, exp_v[c]); end
            checks++;
            if (imem_pc !== exp_pc[c]) begin errors++; $display("FAIL drain_imem_pc c%0d got %h exp %h", c, imem_pc, exp_pc[c]); end
            if (exp_v[c]) begin
                checks++;
                if (id_pc !== exp_id[c]) begin errors++; $display("FAIL drain_id_pc c%0d got %h exp %h", c, id_pc, exp_id[c]); end
            end
            step();
        end
    endtask

    task automatic test_redirect();
        logic        exp_v  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exp_pc [5] = '{32'h40, 32'h40, 32'h44, 32'h44, 32'h48};
        logic [31:0] exp_id [5] = '{32'h0, 32'h0, 32'h40, 32'h0, 32'h44};
        id_ready = 1'b0;
        do_reset();
        repeat (5) step();
        checks++; if (imem_valid !== 1'b1) begin errors++; $display("FAIL redir_pre_valid got %b exp 1", imem_valid); end
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        id_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (id_valid !== exp_v[c]) begin errors++; $display("FAIL redir_id_valid c%0d got %b exp %b", c, id_valid, exp_v[c]); end
            checks++;
            if (imem_pc !== exp_pc[c]) begin errors++; $display("FAIL redir_imem_pc c%0d got %h exp %h", c, imem_pc, exp_pc[c]); end
            if (exp_v[c]) begin
                checks++;
                if (id_pc !== exp_id[c]) begin errors++; $display("FAIL redir_id_pc c%0d got %h exp %h", c, id_pc, exp_id[c]); end
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        id_ready = 1'b0;
        do_reset();
        step();
        step();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", id_valid); end
        checks++; if (imem_pc !== 32'h4) begin errors++; $display("FAIL mid_pre_imem_pc got %h exp 4", imem_pc); end
        rst = 1'b1;
        step();
        rst      = 1'b0;
        id_ready = 1'b1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL mid_id_valid got %b exp 0", id_valid); end
        checks++; if (imem_pc !== 32'h0) begin errors++; $display("FAIL mid_imem_pc got %h exp 0", imem_pc); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL mid_id_pc got %h exp 0", id_pc); end
        step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL mid_c1_valid got %b exp 0", id_valid); end
        step();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL mid_resume_valid got %b exp 1", id_valid); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL mid_resume_pc got %h exp 0", id_pc); end
        checks++; if (imem_pc !== 32'h4) begin errors++; $display("FAIL mid_resume_imem_pc got %h exp 4", imem_pc); end
    endtask

`ifdef FETCH_MISALIGN_CHK_EN
    task automatic test_misalign();
        id_ready = 1'b1;
        do_reset();
        checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL mis_reset got %b exp 0", fetch_misalign); end
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h42;
        step();
        redirect = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++; if (fetch_misalign !== 1'b1) begin errors++; $display("FAIL mis_flag c%0d got %b exp 1", c, fetch_misalign); end
            checks++; if (imem_pc !== 32'h40) begin errors++; $display("FAIL mis_imem_pc c%0d got %h exp 40", c, imem_pc); end
            checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL mis_id_valid c%0d got %b exp 0", c, id_valid); end
            step();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got %b exp 0", fetch_misalign); end
        checks++; if (imem_pc !== 32'h80) begin errors++; $display("FAIL mis_clear_pc got %h exp 80", imem_pc); end
        step();
        step();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL mis_resume_valid got %b exp 1", id_valid); end
        checks++; if (id_pc !== 32'h80) begin errors++; $display("FAIL mis_resume_pc got %h exp 80", id_pc); end
    endtask
`else
    task automatic test_unaligned_redirect();
        id_ready = 1'b1;
        do_reset();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h42;
        step();
        redirect = 1'b0;
        checks++; if (imem_pc !== 32'h40) begin errors++; $display("FAIL unal_imem_pc got %h exp 40", imem_pc); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL unal_id_valid got %b exp 0", id_valid); end
        step();
        step();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL unal_resume_valid got %b exp 1", id_valid); end
        checks++; if (id_pc !== 32'h40) begin errors++; $display("FAIL unal_resume_pc got %h exp 40", id_pc); end
        checks++; if (id_instr !== 32'hC0DE_0040) begin errors++; $display("FAIL unal_resume_instr got %h exp c0de0040", id_instr); end
        checks++; if (imem_pc !== 32'h44) begin errors++; $display("FAIL unal_next_pc got %h exp 44", imem_pc); end
    endtask
`endif

    initial begin
        test_reset();
        test_stall_and_full_push_pop();
        test_redirect();
        test_reset_mid();
`ifdef FETCH_MISALIGN_CHK_EN
        test_misalign();
`else
        test_unaligned_redirect();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction memory and drives its PC input.
- Holds the architectural fetch PC and presents it to the memory, waiting until the memory returns a valid word for that PC.
- Pushes each fetched {pc, instr} pair into a small output buffer that feeds decode through a valid/ready handshake.
- Accepts branch/jump redirects from the execute stage, which flush the buffer and restart fetch at the target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
BUF_DEPTH, 2, output buffer entries; a power of two, minimum 2.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  reset, synchronous, active-high.
imem_pc  output  32  PC to instruction memory; equals the internal pc register.
imem_instr  input  32  word returned by memory; one-cycle read latency.
imem_valid  input  1  high when imem_instr corresponds to the current imem_pc.
redirect  input  1  branch/jump taken; one-cycle pulse from execute.
redirect_pc  input  32  target PC when redirect is high.
id_valid  output  1  buffer head holds a valid instruction.
id_ready  input  1  decode accepts the head this cycle.
id_instr  output  32  instruction at buffer head.
id_pc  output  32  PC of the instruction at buffer head.

Behaviour:
- Reset values (rst high at a clock edge):
  - pc = RESET_PC.
  - Buffer emptied; count = 0.
  - id_valid = 0; id_instr = 0; id_pc = 0.
  - Reset mid-operation discards all buffered and in-flight state.
- Memory protocol:
  - imem_pc must stay stable until imem_valid is seen.
  - The memory only asserts valid when the PC is unchanged from the previous cycle.
  - Peak throughput is therefore 1 instruction per 2 cycles.
  - imem_valid is ignored in the first cycle after reset; the memory guarantees it is low then.
- Push condition: imem_valid && !redirect && (count < BUF_DEPTH || pop).
  - On push: write {pc, imem_instr} at the tail, then pc <= pc + 4 with 32-bit wrap-around.
- Pop condition: id_valid && id_ready.
  - On pop: advance the head.
  - Simultaneous push and pop leaves count unchanged and is legal when full.
- Full buffer with imem_valid and no pop:
  - pc is held, so the memory re-presents the same word next cycle.
  - Nothing is lost.
- Redirect (highest priority after rst):
  - pc <= redirect_pc; buffer flushed (count = 0); id_valid = 0 next cycle.
  - Any concurrent push and pop are suppressed.
  - A concurrent imem_valid word is dropped.
  - Stale memory data cannot reappear, because the PC change forces imem_valid low for one cycle.
- Outputs are driven from the buffer head register, not combinationally from imem_instr.
  - Minimum latency from imem_valid to id_valid is 1 cycle.
- id_instr and id_pc are held stable while id_valid && !id_ready; the downstream stage relies on this.
- No other states exist; the FSM is implicit in (count, pc).

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- When defined:
  - Adds output port fetch_misalign (1 bit), reset 0.
  - If redirect_pc[1:0] != 2'b00, the redirect still flushes the buffer.
  - pc is loaded with {redirect_pc[31:2], 2'b00}.
  - fetch_misalign goes high and fetch halts: no further pushes, pc held.
  - Fetch stays halted until rst or until a subsequent aligned redirect clears it.
- When undefined:
  - Port absent.
  - Redirect loads redirect_pc[31:2] with the low two bits forced to 0.
  - Fetch continues normally.

Test Plan:
- Reset with RESET_PC=0, id_ready=1, memory model with one-cycle latency -> imem_pc sequence 0,0,4,4,8,8; id_pc 0,4,8 each valid for 1 cycle; id_instr matches memory words.
- id_ready=0 for 10 cycles after reset, BUF_DEPTH=2 -> exactly 2 entries accepted (pc 0,4); imem_pc holds 8; no overwrite. Then id_ready=1 -> pops 0,4,8 in order.
- Redirect to 0x40 while buffer holds 2 entries and imem_valid=1 -> next cycle id_valid=0 and imem_pc=0x40; first delivered id_pc=0x40; neither the dropped word nor the old entries ever appear.
- Buffer full, id_ready=1 and imem_valid=1 in the same cycle -> count stays 2; head advances; new entry appended; pc += 4.
- rst pulsed mid-stream with 1 entry buffered -> next cycle id_valid=0 and imem_pc=RESET_PC; fetch resumes from RESET_PC.
- With FETCH_MISALIGN_CHK_EN: redirect_pc=0x42 -> fetch_misalign=1, imem_pc=0x40 held, no pushes. Then redirect_pc=0x80 -> fetch_misalign=0 and fetch resumes at 0x80.
